// File: rtl/usb2_slavefifo_ctrl.sv
// FPGA-side master for the Cypress FX2/FX3 16-bit slave-FIFO bus with round-robin RX/TX arbitration.
// Define USB2_PKTEND_EN to commit short IN packets with a one-cycle usb_pktend strobe.
module usb2_slavefifo_ctrl #(
  parameter int unsigned BURST_LEN = 256,
  parameter int unsigned CNT_W     = 16,
  parameter logic [1:0]  RX_ADDR   = 2'b00,
  parameter logic [1:0]  TX_ADDR   = 2'b10
) (
  input  logic        usb_clk,
  input  logic        rst,
  input  logic        usb_flaga,
  input  logic        usb_flagb,
  output logic [1:0]  usb_fifoaddr,
  output logic        usb_slcs,
  output logic        usb_sloe,
  output logic        usb_slrd,
  output logic        usb_slwr,
  output logic        usb_pktend,
  input  logic [15:0] usb_fd_i,
  output logic [15:0] usb_fd_o,
  output logic        usb_fd_oe,
  input  logic        rx_en,
  input  logic        tx_en,
  output logic [15:0] rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  input  logic [15:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    RD_SETUP,
    RD_DATA,
    WR_SETUP,
    WR_DATA,
`ifdef USB2_PKTEND_EN
    PKTEND,
`endif
    TURN
  } state_t;

  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST_LEN);

  state_t           state_q, state_d;
  logic             last_tx_q;     // 1 = TX held the bus last, so RX wins the next tie
  logic [CNT_W-1:0] beat_q;
  logic [15:0]      rx_data_q;
  logic             rx_valid_q;
  logic             rd_req, wr_req, rd_fire, wr_fire, beat_lt;

  assign rd_req  = rx_en & usb_flaga;
  assign wr_req  = tx_en & tx_valid & ~usb_flagb;
  assign beat_lt = (beat_q < BURST_MAX);

  always_comb begin
    state_d      = state_q;
    rd_fire      = 1'b0;
    wr_fire      = 1'b0;
    usb_slcs     = 1'b0;
    usb_sloe     = 1'b1;
    usb_fd_oe    = 1'b0;
    usb_fifoaddr = RX_ADDR;
    usb_pktend   = 1'b1;
    case (state_q)
      IDLE: begin
        usb_slcs = 1'b1;
        if (rd_req && (!wr_req || last_tx_q)) state_d = RD_SETUP;
        else if (wr_req)                      state_d = WR_SETUP;
      end
      RD_SETUP: begin
        usb_sloe = 1'b0;
        state_d  = RD_DATA;
      end
      RD_DATA: begin
        usb_sloe = 1'b0;
        rd_fire  = usb_flaga & (~rx_valid_q | rx_ready) & beat_lt;
        if (!beat_lt || !usb_flaga) state_d = TURN;
      end
      WR_SETUP: begin
        usb_fifoaddr = TX_ADDR;
        usb_fd_oe    = 1'b1;
        state_d      = WR_DATA;
      end
      WR_DATA: begin
        usb_fifoaddr = TX_ADDR;
        usb_fd_oe    = 1'b1;
        wr_fire      = tx_valid & ~usb_flagb & beat_lt;
        if (!beat_lt || usb_flagb) state_d = TURN;
`ifdef USB2_PKTEND_EN
        else if (!tx_valid)        state_d = (beat_q != '0) ? PKTEND : TURN;
`else
        else if (!tx_valid)        state_d = TURN;
`endif
      end
`ifdef USB2_PKTEND_EN
      PKTEND: begin
        usb_fifoaddr = TX_ADDR;
        usb_fd_oe    = 1'b1;
        usb_pktend   = 1'b0;
        state_d      = TURN;
      end
`endif
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge usb_clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_tx_q  <= 1'b1;
      beat_q     <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && state_d == RD_SETUP) last_tx_q <= 1'b0;
      if (state_q == IDLE && state_d == WR_SETUP) last_tx_q <= 1'b1;
      // fire terms already require beat < BURST_LEN, so the counter saturates instead of wrapping
      if (state_q == RD_SETUP || state_q == WR_SETUP) beat_q <= '0;
      else if (rd_fire || wr_fire)                    beat_q <= beat_q + 1'b1;
      if (rd_fire) begin
        rx_data_q  <= usb_fd_i;
        rx_valid_q <= 1'b1;
      end else if (rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign usb_slrd = ~rd_fire;
  assign usb_slwr = ~wr_fire;
  assign tx_ready = wr_fire;
  assign usb_fd_o = (state_q == WR_DATA) ? tx_data : '0;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_usb2_slavefifo_ctrl.sv
// Directed bench for usb2_slavefifo_ctrl: FX2-style FIFO model, RX/TX bursts, arbitration and mid-tenure reset.
// Honours USB2_PKTEND_EN when the same define is given to the bench.
module tb_usb2_slavefifo_ctrl;

  localparam int unsigned BL = 64;
`ifdef USB2_PKTEND_EN
  localparam int unsigned EXP_PKT = 1;
`else
  localparam int unsigned EXP_PKT = 0;
`endif

  logic        usb_clk = 1'b0;
  logic        rst;
  logic        usb_flaga, usb_flagb;
  logic [1:0]  usb_fifoaddr;
  logic        usb_slcs, usb_sloe, usb_slrd, usb_slwr, usb_pktend;
  logic [15:0] usb_fd_i, usb_fd_o;
  logic        usb_fd_oe;
  logic        rx_en, tx_en;
  logic [15:0] rx_data;
  logic        rx_valid, rx_ready;
  logic [15:0] tx_data;
  logic        tx_valid, tx_ready, busy;

  always #5 usb_clk = ~usb_clk;

  usb2_slavefifo_ctrl #(
    .BURST_LEN(BL),
    .CNT_W(16),
    .RX_ADDR(2'b00),
    .TX_ADDR(2'b10)
  ) dut (
    .usb_clk(usb_clk), .rst(rst),
    .usb_flaga(usb_flaga), .usb_flagb(usb_flagb),
    .usb_fifoaddr(usb_fifoaddr), .usb_slcs(usb_slcs), .usb_sloe(usb_sloe),
    .usb_slrd(usb_slrd), .usb_slwr(usb_slwr), .usb_pktend(usb_pktend),
    .usb_fd_i(usb_fd_i), .usb_fd_o(usb_fd_o), .usb_fd_oe(usb_fd_oe),
    .rx_en(rx_en), .tx_en(tx_en),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy)
  );

  int unsigned n_cmp = 0, n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] vip_word(input int unsigned k);
    logic [31:0] v;
    v = 32'h0100 + k * 32'h0202;
    return v[15:0];
  endfunction

  // OUT endpoint model: pops one word per low slrd at the clock edge
  int unsigned vip_ptr = 0, vip_len;
  logic        vip_clr;
  always @(posedge usb_clk)
    if (vip_clr)        vip_ptr <= 0;
    else if (!usb_slrd) vip_ptr <= vip_ptr + 1;
  assign usb_flaga = (vip_ptr < vip_len);
  assign usb_fd_i  = vip_word(vip_ptr);

  // tx stream source: word value equals its index
  int unsigned tx_idx = 0, tx_len;
  logic        tx_on, tx_clr;
  always @(posedge usb_clk)
    if (tx_clr)                    tx_idx <= 0;
    else if (tx_valid && tx_ready) tx_idx <= tx_idx + 1;
  assign tx_valid = tx_on && (tx_idx < tx_len);
  assign tx_data  = 16'(tx_idx);

  // bus monitor sampled mid-cycle
  int unsigned rd_strb = 0, wr_strb = 0, overlap = 0, pkt_cnt = 0, oe_hi = 0;
  int unsigned uflow = 0, wr_bad = 0, tenures = 0;
  logic [1:0]  ten_addr [0:255];
  int unsigned ten_words [0:255];
  logic        busy_d = 1'b0;
  always @(negedge usb_clk) begin
    busy_d <= busy;
    if (!usb_slrd) rd_strb <= rd_strb + 1;
    if (!usb_slwr) wr_strb <= wr_strb + 1;
    if (!usb_slrd && !usb_slwr) overlap <= overlap + 1;
    if (!usb_pktend) pkt_cnt <= pkt_cnt + 1;
    if (usb_fd_oe) oe_hi <= oe_hi + 1;
    if (!usb_slrd && !usb_flaga) uflow <= uflow + 1;
    if (!usb_slwr && (usb_fd_o != 16'(tx_idx) || !usb_fd_oe)) wr_bad <= wr_bad + 1;
    if (busy && !busy_d) begin
      ten_addr[tenures[7:0]] <= usb_fifoaddr;
      ten_words[tenures[7:0]] <= 0;
      tenures <= tenures + 1;
    end else if ((!usb_slrd || !usb_slwr) && tenures > 0) begin
      ten_words[8'(tenures - 1)] <= ten_words[8'(tenures - 1)] + 1;
    end
  end

  int unsigned s_rd, s_wr, s_ov, s_pk, s_oe, s_uf, s_bad, s_ten;
  task automatic snap();
    s_rd = rd_strb; s_wr = wr_strb; s_ov = overlap; s_pk = pkt_cnt;
    s_oe = oe_hi; s_uf = uflow; s_bad = wr_bad; s_ten = tenures;
  endtask

  task automatic rx_collect(input int unsigned first, input int unsigned n, input bit toggle,
                            input int unsigned budget);
    int unsigned idx, cyc;
    idx = first;
    cyc = 0;
    while (idx < first + n && cyc < budget) begin
      @(negedge usb_clk);
      cyc++;
      rx_ready = toggle ? ~rx_ready : 1'b1;
      #1;
      if (rx_valid && rx_ready) begin
        check_eq("rx_data", {16'h0, rx_data}, {16'h0, vip_word(idx)});
        idx++;
      end
    end
    if (idx < first + n) check_eq("rx_timeout", idx, first + n);
  endtask

  task automatic wait_idle(input string tag, input int unsigned budget);
    int unsigned c;
    c = 0;
    while (busy && c < budget) begin
      @(negedge usb_clk);
      c++;
    end
    check_eq(tag, {31'h0, busy}, 32'h0);
  endtask

  task automatic vip_reload(input int unsigned len);
    @(posedge usb_clk); #1;
    vip_clr = 1'b1;
    @(posedge usb_clk); #1;
    vip_clr = 1'b0;
    vip_len = len;
  endtask

  task automatic rx_burst_test(input bit toggle, input string tag);
    snap();
    vip_reload(256);
    rx_en = 1'b1;
    rx_collect(0, 256, toggle, 2000);
    wait_idle({tag, "_idle"}, 100);
    rx_en = 1'b0;
    check_eq({tag, "_strobes"}, rd_strb - s_rd, 256);
    check_eq({tag, "_tenures"}, tenures - s_ten, 4);
    check_eq({tag, "_fd_oe"}, oe_hi - s_oe, 0);
    check_eq({tag, "_overlap"}, overlap - s_ov, 0);
    check_eq({tag, "_underflow"}, uflow - s_uf, 0);
    for (int unsigned k = 0; k < 4; k++) begin
      check_eq({tag, "_ten_words"}, ten_words[8'(s_ten + k)], BL);
      check_eq({tag, "_ten_addr"}, {30'h0, ten_addr[8'(s_ten + k)]}, 32'h0);
    end
  endtask

  initial begin
    int unsigned c;
    rst = 1'b1; vip_clr = 1'b1; vip_len = 0; tx_clr = 1'b1; tx_on = 1'b0; tx_len = 0;
    rx_en = 1'b0; tx_en = 1'b0; rx_ready = 1'b0; usb_flagb = 1'b0;
    #1;
    check_eq("rst_strobes", {27'h0, usb_slcs, usb_sloe, usb_slrd, usb_slwr, usb_pktend}, 32'h1F);
    check_eq("rst_fifoaddr", {30'h0, usb_fifoaddr}, 32'h0);
    check_eq("rst_fd", {15'h0, usb_fd_oe, usb_fd_o}, 32'h0);
    check_eq("rst_rx", {14'h0, busy, rx_valid, rx_data}, 32'h0);
    check_eq("rst_tx_ready", {31'h0, tx_ready}, 32'h0);
    repeat (3) @(posedge usb_clk);
    #1;
    rst = 1'b0; vip_clr = 1'b0; tx_clr = 1'b0;

    rx_burst_test(1'b0, "rx_full");
    rx_burst_test(1'b1, "rx_toggle");

    // IN FIFO full: no tenure may start
    snap();
    tx_len = 10; tx_on = 1'b1; tx_en = 1'b1; usb_flagb = 1'b1;
    repeat (10) @(negedge usb_clk);
    check_eq("flagb_busy", {31'h0, busy}, 32'h0);
    check_eq("flagb_writes", wr_strb - s_wr, 0);
    usb_flagb = 1'b0;
    c = 0;
    while (tx_idx < 10 && c < 200) begin
      @(negedge usb_clk);
      c++;
    end
    check_eq("tx_words", tx_idx, 10);
    wait_idle("tx_idle", 50);
    check_eq("tx_strobes", wr_strb - s_wr, 10);
    check_eq("tx_data_oe", wr_bad - s_bad, 0);
    check_eq("tx_pktend", pkt_cnt - s_pk, EXP_PKT);
    check_eq("tx_tenures", tenures - s_ten, 1);
    check_eq("tx_addr", {30'h0, ten_addr[8'(s_ten)]}, 32'h2);
    check_eq("tx_ten_words", ten_words[8'(s_ten)], 10);
    tx_on = 1'b0; tx_en = 1'b0;

    // both paths saturated: grants alternate, RX first after the TX tenure
    vip_reload(100000);
    tx_clr = 1'b1;
    @(posedge usb_clk); #1;
    tx_clr = 1'b0; tx_len = 100000; tx_on = 1'b1;
    snap();
    rx_ready = 1'b1; rx_en = 1'b1; tx_en = 1'b1;
    c = 0;
    while (tenures < s_ten + 5 && c < 3000) begin
      @(negedge usb_clk);
      c++;
    end
    check_eq("alt_count", (tenures >= s_ten + 5) ? 32'd1 : 32'd0, 32'd1);
    for (int unsigned k = 0; k < 4; k++) begin
      check_eq("alt_addr", {30'h0, ten_addr[8'(s_ten + k)]}, (k % 2 == 0) ? 32'h0 : 32'h2);
      check_eq("alt_words", ten_words[8'(s_ten + k)], BL);
    end
    check_eq("alt_overlap", overlap - s_ov, 0);
    check_eq("alt_tx_data", wr_bad - s_bad, 0);
    rx_en = 1'b0; tx_en = 1'b0; tx_on = 1'b0;
    wait_idle("alt_idle", 200);

    // asynchronous reset in the middle of a read tenure
    vip_reload(256);
    rx_ready = 1'b1; rx_en = 1'b1;
    c = 0;
    while (vip_ptr < 100 && c < 500) begin
      @(posedge usb_clk); #1;
      c++;
    end
    check_eq("rrst_reach", vip_ptr, 100);
    check_eq("rrst_busy_pre", {31'h0, busy}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check_eq("rrst_strobes", {27'h0, usb_slcs, usb_sloe, usb_slrd, usb_slwr, usb_pktend}, 32'h1F);
    check_eq("rrst_state", {29'h0, busy, rx_valid, usb_fd_oe}, 32'h0);
    @(posedge usb_clk);
    @(negedge usb_clk);
    rst = 1'b0;
    check_eq("rrst_no_pop", vip_ptr, 100);
    rx_collect(100, 156, 1'b0, 1000);
    wait_idle("rrst_idle", 100);
    check_eq("rrst_overlap", overlap - s_ov, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
